// File: rtl/spi_master_ram_if_if.sv
// Host request/response handshake plus SPI pins for spi_master_ram_if.
// master is the SPI master's view; slave is the host/bench view.
interface spi_master_ram_if_if;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  start, cmd, din, MISO,
        output busy, done, rdata, rdata_valid, SS_n, MOSI
    );

    modport slave (
        output start, cmd, din, MISO,
        input  busy, done, rdata, rdata_valid, SS_n, MOSI
    );
endinterface

// File: rtl/spi_master_ram_if.sv
// SPI master for the serial RAM protocol: serializes {rw, cmd, din} on MOSI under SS_n
// and, for read-data commands, captures the returned byte from MISO.
module spi_master_ram_if #(
    parameter int unsigned RD_WAIT  = 3,
    parameter int unsigned TAIL_CYC = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_master_ram_if_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SEND,
        WAIT_RD,
        RECV,
        TAIL
    } state_t;

    localparam logic [3:0] SEND_LAST = 4'd10;
    localparam logic [3:0] RECV_LAST = 4'd7;
    localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);
    localparam logic [3:0] TAIL_LAST = 4'(TAIL_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [10:0] shift_q, shift_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [6:0]  rx_q, rx_d;
    logic        ss_n_q, ss_n_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;

    // Outputs are registered from the state being entered, so each pin
    // changes on the same edge as the state transition that causes it.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        cmd_d         = cmd_q;
        rx_d          = rx_q;
        ss_n_d        = 1'b0;
        mosi_d        = 1'b0;
        busy_d        = 1'b1;
        done_d        = 1'b0;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                ss_n_d = 1'b1;
                busy_d = 1'b0;
                if (bus.start) begin
                    shift_d = {bus.cmd[1], bus.cmd, bus.din};
                    cmd_d   = bus.cmd;
                    state_d = SELECT;
                    ss_n_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SELECT: begin
                state_d = SEND;
                cnt_d   = '0;
                mosi_d  = shift_q[10];
                shift_d = {shift_q[9:0], 1'b0};
            end
            SEND: begin
                if (cnt_q == SEND_LAST) begin
                    cnt_d   = '0;
                    state_d = (cmd_q == 2'b11) ? WAIT_RD : TAIL;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    mosi_d  = shift_q[10];
                    shift_d = {shift_q[9:0], 1'b0};
                end
            end
            WAIT_RD: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RECV;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RECV: begin
                rx_d = {rx_q[5:0], bus.MISO};
                if (cnt_q == RECV_LAST) begin
                    state_d       = IDLE;
                    ss_n_d        = 1'b1;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    rdata_d       = {rx_q, bus.MISO};
                    rdata_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            TAIL: begin
                if (cnt_q == TAIL_LAST) begin
                    state_d = IDLE;
                    ss_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                ss_n_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            cmd_q         <= '0;
            rx_q          <= '0;
            ss_n_q        <= 1'b1;
            mosi_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            cmd_q         <= cmd_d;
            rx_q          <= rx_d;
            ss_n_q        <= ss_n_d;
            mosi_q        <= mosi_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign bus.SS_n        = ss_n_q;
    assign bus.MOSI        = mosi_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
endmodule

// File: doc/spi_master_ram_if.md
Name: spi_master_ram_if

Overview:
- SPI master that drives the serial RAM protocol used by the team's SPI slave/RAM wrapper.
- Accepts one command per host request (write address, write data, read address, read data) and serializes it on MOSI under SS_n.
- For read-data commands it also captures the returned byte from MISO.
- Sits between a host/bench sequencer and the SPI slave; shares the slave's clk, so there is no separate SCLK.

Parameters:
- RD_WAIT, 3, cycles between the last MOSI bit and the first MISO sample in a read-data frame (range 1..15).
- TAIL_CYC, 1, SS_n-low cycles after the last MOSI bit in non-read-data frames (range 1..7).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request strobe; accepted only when busy=0.
- cmd  input  2  00 write address, 01 write data, 10 read address, 11 read data.
- din  input  8  address or data byte; don't-care for cmd=11.
- busy  output  1  high from the cycle after acceptance until the frame ends.
- done  output  1  one-cycle pulse at frame end.
- rdata  output  8  byte captured in a read-data frame.
- rdata_valid  output  1  one-cycle pulse with done, for cmd=11 only.
- SS_n  output  1  slave select, active-low.
- MOSI  output  1  serial data to slave.
- MISO  input  1  serial data from slave.

Behaviour:
- All outputs are registered.
- Reset values: SS_n=1, MOSI=0, busy=0, done=0, rdata=0x00, rdata_valid=0. The FSM resets to IDLE.
- FSM states: IDLE, SELECT, SEND, WAIT_RD, RECV, TAIL.
- IDLE:
  - SS_n=1, MOSI=0.
  - When start=1 at an edge: latch shift word {cmd[1], cmd, din} (11 bits, MSB first), latch cmd, go to SELECT.
- SELECT (1 cycle): SS_n=0, MOSI=0, busy=1.
- SEND (11 cycles): SS_n=0; MOSI presents shift-word bits 10 down to 0, one bit per cycle.
  - Bit 10 is the read/write flag (equals cmd[1]).
  - Bits 9:8 are cmd; bits 7:0 are din, MSB first.
- After SEND:
  - cmd=11 goes to WAIT_RD.
  - Any other cmd goes to TAIL.
- TAIL (TAIL_CYC cycles): SS_n=0, MOSI=0. Then return to IDLE.
- WAIT_RD (RD_WAIT cycles): SS_n=0, MOSI=0. Then go to RECV.
- RECV (8 cycles): SS_n=0, MOSI=0. At each edge, shift MISO into the receive register, MSB first. Then return to IDLE.
- Frame end (return to IDLE):
  - On the same edge: SS_n=1, busy=0, done=1 for exactly 1 cycle.
  - For cmd=11 only: rdata is updated with the received byte and rdata_valid=1 for exactly 1 cycle.
  - rdata holds its value until the next read-data frame completes or reset.
- Frame lengths (SS_n low cycles):
  - Write/read-address: 1+11+TAIL_CYC = 13 at defaults.
  - Read-data: 1+11+RD_WAIT+8 = 23 at defaults.
- Latency: start to done = frame length + 1 cycles.
- Boundary conditions:
  - start while busy=1: ignored, no queuing; the in-flight frame is unaffected.
  - cmd/din changes while busy: ignored (latched at acceptance).
  - Back-to-back: start high in the done cycle is accepted. SS_n is high for exactly 1 cycle between frames (minimum inter-frame gap).
  - Reset mid-frame: at the next edge with rst_n=0, all outputs take reset values and the FSM returns to IDLE. No done or rdata_valid is generated; rdata returns to 0x00.
  - start asserted together with rst_n=0: reset wins.
  - MISO is ignored outside RECV.
  - Counters are 4 bits and saturate-free. Each state's exit is exact on count terminal; no wrap-around is observable.

Test Plan:
- Write address: reset, start with cmd=00, din=0xA5 -> SS_n low 13 cycles; MOSI sequence 0,0,0,0,1,0,1,0,0,1,0,1,0; done pulse 14 cycles after start; rdata_valid stays 0.
- Read data: cmd=11, bench drives MISO 1,1,0,0,1,0,1,0 in the 8 RECV cycles -> MOSI 0,1,1,1 then eight 0s then 0s; SS_n low 23 cycles; rdata=0xCA with rdata_valid=done=1 for one cycle.
- Busy rejection: start cmd=01, din=0x3C, then pulse start cmd=10, din=0xFF at cycle 5 -> only the 0x3C frame appears; a single done.
- Back-to-back: hold start=1 with cmd=10, din=0x12 -> two identical frames separated by exactly one SS_n-high cycle; two done pulses 14 cycles apart.
- Reset mid-frame: rst_n=0 in cycle 6 of a cmd=01 frame -> next edge SS_n=1, MOSI=0, busy=0; no done; a following cmd=00 frame is correct.
- Parameter sweep: RD_WAIT=1 and TAIL_CYC=3 -> read-data SS_n low 21 cycles; write frame SS_n low 15 cycles.
